// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID-stage hazard request and tracked EX/MEM/WB destinations/latencies.
// STALL_STATS_EN adds the stall statistics counters to the bundle.
interface hazard_stall_controller_if;
  logic [4:0] RA1_ID, RA2_ID, WA_ID;
  logic [1:0] Tuse1_ID, Tuse2_ID, Tnew_ID;
  logic       md_start_ID, md_div_ID, md_access_ID;
  logic       stall, md_busy;
  logic [4:0] WA_EX, WA_MEM, WA_WB;
  logic [1:0] Tnew_EX, Tnew_MEM, Tnew_WB;
`ifdef STALL_STATS_EN
  logic [31:0] stall_data_cnt, stall_md_cnt;
  modport master (
    output RA1_ID, RA2_ID, WA_ID, Tuse1_ID, Tuse2_ID, Tnew_ID, md_start_ID, md_div_ID, md_access_ID,
    input  stall, md_busy, WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB, stall_data_cnt, stall_md_cnt
  );
  modport slave (
    input  RA1_ID, RA2_ID, WA_ID, Tuse1_ID, Tuse2_ID, Tnew_ID, md_start_ID, md_div_ID, md_access_ID,
    output stall, md_busy, WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB, stall_data_cnt, stall_md_cnt
  );
`else
  modport master (
    output RA1_ID, RA2_ID, WA_ID, Tuse1_ID, Tuse2_ID, Tnew_ID, md_start_ID, md_div_ID, md_access_ID,
    input  stall, md_busy, WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB
  );
  modport slave (
    input  RA1_ID, RA2_ID, WA_ID, Tuse1_ID, Tuse2_ID, Tnew_ID, md_start_ID, md_div_ID, md_access_ID,
    output stall, md_busy, WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB
  );
`endif
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: tracks WA/Tnew through EX/MEM/WB and stalls ID on uncovered data or mult/div hazards.
// Optional macro STALL_STATS_EN adds per-cause stall cycle counters.
module hazard_stall_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  hazard_stall_controller_if.slave hz
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1) > 4 ? $clog2(MAX_CYCLES + 1) : 4;
  logic [4:0] wa_ex_q, wa_mem_q, wa_wb_q, wa_ex_d, wa_mem_d, wa_wb_d;
  logic [1:0] tnew_ex_q, tnew_mem_q, tnew_wb_q, tnew_ex_d, tnew_mem_d, tnew_wb_d;
  logic       md_start_ex_q, md_start_ex_d, md_div_ex_q, md_div_ex_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       data_hit, md_stall, stall;
  // WB never stalls: its value is always forwardable by the time ID needs it
  function automatic logic src_hit(input logic [4:0] ra, input logic [1:0] tuse);
    return ra != 5'd0 && ((ra == wa_ex_q && tnew_ex_q > tuse) || (ra == wa_mem_q && tnew_mem_q > tuse));
  endfunction
  always_comb begin
    data_hit      = src_hit(hz.RA1_ID, hz.Tuse1_ID) || src_hit(hz.RA2_ID, hz.Tuse2_ID);
    md_stall      = hz.md_access_ID && (md_start_ex_q || cnt_q != '0);
    stall         = data_hit || md_stall;
    wa_ex_d       = stall ? 5'd0 : hz.WA_ID;
    tnew_ex_d     = stall ? 2'd0 : hz.Tnew_ID;
    wa_mem_d      = wa_ex_q;
    tnew_mem_d    = tnew_ex_q - {1'b0, tnew_ex_q != 2'd0};
    wa_wb_d       = wa_mem_q;
    tnew_wb_d     = tnew_mem_q - {1'b0, tnew_mem_q != 2'd0};
    md_start_ex_d = hz.md_start_ID && !stall;
    md_div_ex_d   = hz.md_div_ID;
    cnt_d         = md_start_ex_q ? (md_div_ex_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES))
                                  : cnt_q - CW'(cnt_q != '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wa_ex_q       <= '0;
      wa_mem_q      <= '0;
      wa_wb_q       <= '0;
      tnew_ex_q     <= '0;
      tnew_mem_q    <= '0;
      tnew_wb_q     <= '0;
      md_start_ex_q <= 1'b0;
      md_div_ex_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      wa_ex_q       <= wa_ex_d;
      wa_mem_q      <= wa_mem_d;
      wa_wb_q       <= wa_wb_d;
      tnew_ex_q     <= tnew_ex_d;
      tnew_mem_q    <= tnew_mem_d;
      tnew_wb_q     <= tnew_wb_d;
      md_start_ex_q <= md_start_ex_d;
      md_div_ex_q   <= md_div_ex_d;
      cnt_q         <= cnt_d;
    end
  end
  assign hz.stall    = stall;
  assign hz.md_busy  = md_start_ex_q || cnt_q != '0;
  assign hz.WA_EX    = wa_ex_q;
  assign hz.WA_MEM   = wa_mem_q;
  assign hz.WA_WB    = wa_wb_q;
  assign hz.Tnew_EX  = tnew_ex_q;
  assign hz.Tnew_MEM = tnew_mem_q;
  assign hz.Tnew_WB  = tnew_wb_q;
`ifdef STALL_STATS_EN
  // a cycle with both causes is attributed to the data counter only
  logic [31:0] data_cnt_q, data_cnt_d, md_cnt_q, md_cnt_d;
  always_comb begin
    data_cnt_d = data_cnt_q + 32'(data_hit);
    md_cnt_d   = md_cnt_q + 32'(md_stall && !data_hit);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_cnt_q <= '0;
      md_cnt_q   <= '0;
    end else begin
      data_cnt_q <= data_cnt_d;
      md_cnt_q   <= md_cnt_d;
    end
  end
  assign hz.stall_data_cnt = data_cnt_q;
  assign hz.stall_md_cnt   = md_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed test-plan scenarios plus randomized run against a history-based model.
module tb_hazard_stall_controller;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  hazard_stall_controller_if hz ();
  hazard_stall_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] wa;
    int         tnew;
  } slot_t;
  slot_t hist[$];
  int md_age = 1000;
  int md_n = 0;
  int m_data_cnt = 0;
  int m_md_cnt = 0;
  function automatic logic [1:0] sat(input int x);
    return x < 0 ? 2'd0 : 2'(x);
  endfunction
  function automatic bit m_src(input logic [4:0] ra, input logic [1:0] tuse);
    if (ra == 5'd0) return 1'b0;
    return (hist[0].wa == ra && hist[0].tnew > int'(tuse)) || (hist[1].wa == ra && hist[1].tnew - 1 > int'(tuse));
  endfunction
  function automatic bit m_data();
    return m_src(hz.RA1_ID, hz.Tuse1_ID) || m_src(hz.RA2_ID, hz.Tuse2_ID);
  endfunction
  function automatic bit m_busy();
    return md_age <= md_n;
  endfunction
  function automatic bit m_md();
    return hz.md_access_ID && m_busy();
  endfunction
  function automatic logic [22:0] m_vec();
    return {m_data() || m_md(), m_busy(), hist[0].wa, sat(hist[0].tnew), hist[1].wa, sat(hist[1].tnew - 1),
            hist[2].wa, sat(hist[2].tnew - 2)};
  endfunction
  task automatic m_clear();
    slot_t z;
    z.wa = '0;
    z.tnew = 0;
    hist = '{z, z, z};
    md_age = 1000;
    md_n = 0;
    m_data_cnt = 0;
    m_md_cnt = 0;
  endtask
  task automatic tick();
    bit dh, mh;
    slot_t s;
    dh = m_data();
    mh = m_md();
    @(posedge clk);
    if (reset) m_clear();
    else begin
      if (dh) m_data_cnt++;
      else if (mh) m_md_cnt++;
      s.wa = (dh || mh) ? 5'd0 : hz.WA_ID;
      s.tnew = (dh || mh) ? 0 : int'(hz.Tnew_ID);
      hist.push_front(s);
      void'(hist.pop_back());
      if (hz.md_start_ID && !(dh || mh)) begin
        md_age = 0;
        md_n = hz.md_div_ID ? DIV_N : MULT_N;
      end else if (md_age < 1000) md_age++;
    end
    #1;
  endtask
  task automatic set_id(input logic [4:0] ra1, input logic [1:0] tu1, input logic [4:0] ra2, input logic [1:0] tu2,
                        input logic [4:0] wa, input logic [1:0] tn, input logic ms, input logic md, input logic ma);
    hz.RA1_ID = ra1;
    hz.Tuse1_ID = tu1;
    hz.RA2_ID = ra2;
    hz.Tuse2_ID = tu2;
    hz.WA_ID = wa;
    hz.Tnew_ID = tn;
    hz.md_start_ID = ms;
    hz.md_div_ID = md;
    hz.md_access_ID = ma;
    #1;
  endtask
  task automatic idle();
    set_id(0, 3, 0, 3, 0, 0, 0, 0, 0);
  endtask
  function automatic logic [22:0] dut_vec();
    return {hz.stall, hz.md_busy, hz.WA_EX, hz.Tnew_EX, hz.WA_MEM, hz.Tnew_MEM, hz.WA_WB, hz.Tnew_WB};
  endfunction
  task automatic test_reset();
    reset = 1'b1;
    set_id(5'd1, 2'd0, 5'd2, 2'd0, 5'd1, 2'd2, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      set_id(5'($urandom), 2'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      tests++;
      if (dut_vec() !== 23'd0) begin
        fails++;
        $display("FAIL reset_state: got %h want 000000", dut_vec());
      end
    end
    idle();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_load_use();
    set_id(0, 3, 0, 3, 5'd1, 2'd2, 0, 0, 0);
    tick();
    set_id(5'd1, 2'd1, 0, 3, 5'd2, 2'd1, 0, 0, 0);
    tests++;
    if (hz.stall !== 1'b1) begin fails++; $display("FAIL lw_add_stall: got %b want 1", hz.stall); end
    tick();
    tests++;
    if ({hz.stall, hz.WA_MEM, hz.Tnew_MEM} !== {1'b0, 5'd1, 2'd1}) begin
      fails++;
      $display("FAIL lw_add_release: got stall=%b wa=%0d tnew=%0d want 0/1/1", hz.stall, hz.WA_MEM, hz.Tnew_MEM);
    end
    tick();
    idle();
    tick();
    tick();
    set_id(0, 3, 0, 3, 5'd1, 2'd2, 0, 0, 0);
    tick();
    set_id(5'd1, 2'd0, 0, 3, 0, 0, 0, 0, 0);
    tests++;
    if (hz.stall !== 1'b1) begin fails++; $display("FAIL lw_beq_stall1: got %b want 1", hz.stall); end
    tick();
    tests++;
    if (hz.stall !== 1'b1) begin fails++; $display("FAIL lw_beq_stall2: got %b want 1", hz.stall); end
    tick();
    tests++;
    if ({hz.stall, hz.WA_WB, hz.Tnew_WB} !== {1'b0, 5'd1, 2'd0}) begin
      fails++;
      $display("FAIL lw_beq_release: got stall=%b wa=%0d tnew=%0d want 0/1/0", hz.stall, hz.WA_WB, hz.Tnew_WB);
    end
`ifdef STALL_STATS_EN
    tests++;
    if ({hz.stall_data_cnt, hz.stall_md_cnt} !== {32'd3, 32'd0}) begin
      fails++;
      $display("FAIL stats_data: got data=%0d md=%0d want 3/0", hz.stall_data_cnt, hz.stall_md_cnt);
    end
`endif
    tick();
    idle();
  endtask
  task automatic test_forward_ok();
    set_id(0, 3, 0, 3, 5'd3, 2'd1, 0, 0, 0);
    tick();
    set_id(0, 3, 5'd3, 2'd2, 0, 0, 0, 0, 0);
    tests++;
    if ({hz.stall, hz.WA_EX, hz.Tnew_EX} !== {1'b0, 5'd3, 2'd1}) begin
      fails++;
      $display("FAIL addu_sw_ex: got stall=%b wa=%0d tnew=%0d want 0/3/1", hz.stall, hz.WA_EX, hz.Tnew_EX);
    end
    tick();
    idle();
    tests++;
    if ({hz.stall, hz.WA_MEM, hz.Tnew_MEM} !== {1'b0, 5'd3, 2'd0}) begin
      fails++;
      $display("FAIL addu_sw_mem: got stall=%b wa=%0d tnew=%0d want 0/3/0", hz.stall, hz.WA_MEM, hz.Tnew_MEM);
    end
    tick();
    tick();
  endtask
  task automatic test_muldiv();
    for (int k = 0; k < 2; k++) begin
      int n;
      int want;
      want = (k == 0 ? DIV_N : MULT_N) + 1;
      n = 0;
      set_id(0, 3, 0, 3, 0, 0, 1'b1, k == 0, 1'b1);
      tick();
      set_id(0, 3, 0, 3, 5'd2, 2'd1, 0, 0, 1'b1);
      while (hz.stall === 1'b1 && hz.md_busy === 1'b1 && n < 40) begin
        n++;
        tick();
      end
      tests++;
      if (n !== want || hz.md_busy !== 1'b0 || hz.stall !== 1'b0) begin
        fails++;
        $display("FAIL md_stall_len%0d: got %0d cycles busy=%b want %0d cycles busy=0", k, n, hz.md_busy, want);
      end
      tick();
      idle();
      tick();
    end
  endtask
  task automatic test_zero_and_reset_mid();
    set_id(0, 3, 0, 3, 5'd0, 2'd2, 0, 0, 0);
    tick();
    set_id(5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0);
    tests++;
    if ({hz.stall, hz.WA_EX, hz.Tnew_EX} !== {1'b0, 5'd0, 2'd2}) begin
      fails++;
      $display("FAIL reg0_no_stall: got stall=%b wa=%0d tnew=%0d want 0/0/2", hz.stall, hz.WA_EX, hz.Tnew_EX);
    end
    idle();
    tick();
    tick();
    set_id(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    tick();
    tick();
    set_id(0, 3, 0, 3, 5'd5, 2'd2, 0, 0, 0);
    tick();
    set_id(5'd5, 2'd0, 0, 3, 0, 0, 0, 0, 1'b1);
    tests++;
    if ({hz.stall, hz.md_busy} !== 2'b11) begin
      fails++;
      $display("FAIL pre_reset_busy: got stall=%b busy=%b want 1/1", hz.stall, hz.md_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (dut_vec() !== 23'd0) begin
      fails++;
      $display("FAIL reset_mid: got %h want 000000", dut_vec());
    end
`ifdef STALL_STATS_EN
    tests++;
    if ({hz.stall_data_cnt, hz.stall_md_cnt} !== 64'd0) begin
      fails++;
      $display("FAIL stats_reset: got data=%0d md=%0d want 0/0", hz.stall_data_cnt, hz.stall_md_cnt);
    end
`endif
    idle();
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [22:0] exp;
      reset = ($urandom_range(0, 39) == 0);
      set_id(5'($urandom_range(0, 3)), 2'($urandom), 5'($urandom_range(0, 3)), 2'($urandom),
             5'($urandom_range(0, 3)), 2'($urandom), $urandom_range(0, 9) == 0, 1'($urandom),
             $urandom_range(0, 3) == 0);
      exp = m_vec();
      tests++;
      if (dut_vec() !== exp) begin
        fails++;
        $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp);
      end
`ifdef STALL_STATS_EN
      tests++;
      if (hz.stall_data_cnt !== 32'(m_data_cnt) || hz.stall_md_cnt !== 32'(m_md_cnt)) begin
        fails++;
        $display("FAIL random_stats_c%0d: got %0d/%0d want %0d/%0d", c, hz.stall_data_cnt, hz.stall_md_cnt,
                 m_data_cnt, m_md_cnt);
      end
`endif
      tick();
    end
    reset = 1'b0;
  endtask
  initial begin
    m_clear();
    idle();
    test_reset();
    test_load_use();
    test_forward_ok();
    test_muldiv();
    test_zero_and_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
